pong_game_ctrl: RTL and testbench

//  Game-level FSM downstream of the pong graphics/physics block. Consumes its level-type

---
 rtl/pong_game_ctrl.sv | 120 ++++++++++++
 tb/tb_pong_game_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game-level controller: ball count, delays, start button, hit/miss pulses
module pong_game_ctrl #(
  parameter int NUM_BALLS  = 3,
  parameter int WAIT_TICKS = 120,
  parameter int BTN_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BTN_W-1:0] btn,
  input  logic             timer_tick,
  input  logic             miss,
  input  logic             hit_left,
  input  logic             hit_right,
  output logic             graph_still,
  output logic             game_over,
  output logic [1:0]       state_o,
  output logic [3:0]       balls_left,
  output logic             hit_pulse,
  output logic             miss_pulse
);

  typedef enum logic [1:0] {
    S_NEWGAME = 2'b00,
    S_PLAY    = 2'b01,
    S_NEWBALL = 2'b10,
    S_OVER    = 2'b11
  } state_t;

  localparam logic [3:0] BALLS_INIT = 4'(NUM_BALLS);
  localparam logic [7:0] WAIT_INIT  = 8'(WAIT_TICKS);

  state_t     state_q, state_d;
  logic [3:0] balls_q, balls_d;
  logic [7:0] timer_q, timer_d;
  logic       miss_q, hl_q, hr_q;
  logic       hit_pulse_q, hit_pulse_d;
  logic       miss_pulse_q, miss_pulse_d;
  logic       btn_any;
  logic       miss_rise;
  logic       hit_rise;

  assign btn_any   = |btn;
  assign miss_rise = miss & ~miss_q;
  assign hit_rise  = (hit_left & ~hl_q) | (hit_right & ~hr_q);

  // Next-state, ball count, delay timer and pulse decode
  always_comb begin
    state_d      = state_q;
    balls_d      = balls_q;
    timer_d      = timer_q;
    hit_pulse_d  = hit_rise & (state_q == S_PLAY);
    miss_pulse_d = miss_rise & (state_q == S_PLAY);
    case (state_q)
      S_NEWGAME: begin
        balls_d = BALLS_INIT;
        if (btn_any) state_d = S_PLAY;
      end
      S_PLAY: begin
        // A miss always wins over a simultaneous hit for the transition
        if (miss_rise) begin
          timer_d = WAIT_INIT;
          if (balls_q > 4'd1) begin
            balls_d = balls_q - 4'd1;
            state_d = S_NEWBALL;
          end else begin
            balls_d = 4'd0;
            state_d = S_OVER;
          end
        end
      end
      S_NEWBALL: begin
        if (timer_q == 8'd0) begin
          if (btn_any) state_d = S_PLAY;
        end else if (timer_tick) begin
          timer_d = timer_q - 8'd1;
        end
      end
      S_OVER: begin
        if (timer_q == 8'd0) begin
          state_d = S_NEWGAME;
          balls_d = BALLS_INIT;
        end else if (timer_tick) begin
          timer_d = timer_q - 8'd1;
        end
      end
      default: state_d = S_NEWGAME;
    endcase
  end

  // State, counters, input edge registers and output pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_NEWGAME;
      balls_q      <= BALLS_INIT;
      timer_q      <= 8'd0;
      miss_q       <= 1'b0;
      hl_q         <= 1'b0;
      hr_q         <= 1'b0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      balls_q      <= balls_d;
      timer_q      <= timer_d;
      miss_q       <= miss;
      hl_q         <= hit_left;
      hr_q         <= hit_right;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
    end
  end

  assign graph_still = (state_q != S_PLAY);
  assign game_over   = (state_q == S_OVER);
  assign state_o     = state_q;
  assign balls_left  = balls_q;
  assign hit_pulse   = hit_pulse_q;
  assign miss_pulse  = miss_pulse_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - scoreboard bench for pong_game_ctrl with reference model
module tb_pong_game_ctrl;

  localparam int NUM  = 3;
  localparam int WAIT = 120;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic       timer_tick, miss, hit_left, hit_right;
  logic       graph_still, game_over, hit_pulse, miss_pulse;
  logic [1:0] state_o;
  logic [3:0] balls_left;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [9:0] vec;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: game phase, balls remaining, ticks still to wait
  int m_st, m_balls, m_wait;
  bit pm, pl, pr, m_hp, m_mp;

  pong_game_ctrl #(.NUM_BALLS(NUM), .WAIT_TICKS(WAIT), .BTN_W(4)) dut (
    .clk(clk), .reset(reset), .btn(btn), .timer_tick(timer_tick),
    .miss(miss), .hit_left(hit_left), .hit_right(hit_right),
    .graph_still(graph_still), .game_over(game_over), .state_o(state_o),
    .balls_left(balls_left), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_step(input bit r, input bit b, input bit tk,
                            input bit m, input bit l, input bit rr);
    bit mr, hr;
    if (r) begin
      m_st = 0; m_balls = NUM; m_wait = 0;
      pm = 0; pl = 0; pr = 0; m_hp = 0; m_mp = 0;
      return;
    end
    mr   = m && !pm;
    hr   = (l && !pl) || (rr && !pr);
    m_hp = hr && (m_st == 1);
    m_mp = mr && (m_st == 1);
    case (m_st)
      0: begin
        m_balls = NUM;
        if (b) m_st = 1;
      end
      1: if (mr) begin
        m_balls = m_balls - 1;
        m_wait  = WAIT;
        m_st    = (m_balls == 0) ? 3 : 2;
      end
      2: begin
        if (m_wait == 0) begin
          if (b) m_st = 1;
        end else if (tk) m_wait = m_wait - 1;
      end
      default: begin
        if (m_wait == 0) begin
          m_st = 0; m_balls = NUM;
        end else if (tk) m_wait = m_wait - 1;
      end
    endcase
    pm = m; pl = l; pr = rr;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Apply one cycle of inputs, predict the post-edge outputs, then step past the edge
  task automatic drive(input bit r, input bit b, input bit tk,
                       input bit m, input bit l, input bit rr);
    exp_t e;
    reset = r; btn = b ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
    timer_tick = tk; miss = m; hit_left = l; hit_right = rr;
    model_step(r, b, tk, m, l, rr);
    e.cyc = cyc + 1;
    e.vec = {2'(m_st), 4'(m_balls), m_st != 1, m_st == 3, m_hp, m_mp};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented output cycle against the queued prediction
  initial begin
    exp_t e;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e   = exp_q.pop_front();
        act = {state_o, balls_left, graph_still, game_over, hit_pulse, miss_pulse};
        checks++;
        if (e.cyc != cyc || act !== e.vec) begin
          errors++;
          $display("FAIL scoreboard cyc=%0d tag=%0d: got st=%0d balls=%0d gs=%0b go=%0b hp=%0b mp=%0b expected st=%0d balls=%0d gs=%0b go=%0b hp=%0b mp=%0b",
                   cyc, e.cyc, act[9:8], act[7:4], act[3], act[2], act[1], act[0],
                   e.vec[9:8], e.vec[7:4], e.vec[3], e.vec[2], e.vec[1], e.vec[0]);
        end
      end
    end
  end

  initial begin
    bit rm, rl, rr;
    // Reset
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("reset_state", state_o, 0);
    chk("reset_still", graph_still, 1);
    chk("reset_balls", balls_left, 3);
    chk("reset_pulses", {hit_pulse, miss_pulse}, 0);
    // Start
    drive(0, 1, 0, 0, 0, 0);
    chk("start_state", state_o, 1);
    chk("start_still", graph_still, 0);
    // Held miss: one decrement, one pulse
    drive(0, 0, 0, 1, 0, 0);
    chk("miss1_pulse", miss_pulse, 1);
    chk("miss1_state", state_o, 2);
    chk("miss1_balls", balls_left, 2);
    repeat (9) drive(0, 0, 0, 1, 0, 0);
    chk("miss_held_pulse", miss_pulse, 0);
    chk("miss_held_balls", balls_left, 2);
    repeat (119) drive(0, 1, 1, 0, 0, 0);
    chk("wait119_state", state_o, 2);
    drive(0, 1, 1, 0, 0, 0);
    chk("wait120_state", state_o, 2);
    drive(0, 1, 0, 0, 0, 0);
    chk("newball_play", state_o, 1);
    // Second and third misses -> OVER
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("miss2_balls", balls_left, 1);
    repeat (120) drive(0, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    chk("play_again", state_o, 1);
    drive(0, 0, 0, 1, 0, 0);
    chk("over_state", state_o, 3);
    chk("over_flag", game_over, 1);
    chk("over_balls", balls_left, 0);
    drive(0, 0, 0, 0, 0, 0);
    repeat (120) drive(0, 1, 1, 0, 0, 0);
    chk("over_wait_state", state_o, 3);
    drive(0, 0, 0, 0, 0, 0);
    chk("newgame_state", state_o, 0);
    chk("newgame_balls", balls_left, 3);
    // Simultaneous hit and miss
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0);
    chk("both_hit", hit_pulse, 1);
    chk("both_miss", miss_pulse, 1);
    chk("both_balls", balls_left, 2);
    chk("both_state", state_o, 2);
    drive(0, 0, 0, 1, 1, 0);
    chk("both_once", {hit_pulse, miss_pulse}, 0);
    // Reset mid-delay
    repeat (70) drive(0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("midreset_state", state_o, 0);
    chk("midreset_balls", balls_left, 3);
    // Randomized play
    rm = 0; rl = 0; rr = 0;
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 7) == 0) rm = ~rm;
      if ($urandom_range(0, 3) == 0) rl = ~rl;
      if ($urandom_range(0, 3) == 0) rr = ~rr;
      drive($urandom_range(0, 999) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1, rm, rl, rr);
    end
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
